gpu_axis_mem_loader: RTL and testbench
======================================

Name: gpu_axis_mem_loader

Overview:
Sequences the host AXI-Stream data channel into a single write port of the GPU data memory. Each packet is a header word followed by payload words. The block parses the header, generates incrementing write addresses, and applies memory backpressure to the stream. It flags malformed packets and exposes status for the host IO registers. It sits between the axis_* inputs of the gpu top level and the data-memory write arbiter.

Parameters:
ADDR_WIDTH, 16, data-memory word-address width (1..16); header base address uses its low ADDR_WIDTH bits
DATA_WIDTH, 32, stream and memory word width (fixed 32; parameter for checking only)

Ports:
axis_clk  in  1  sole clock; all logic rising-edge
axis_aresetn  in  1  asynchronous active-low reset
axis_tdata  in  32  stream word
axis_tkeep  in  1  1 = word carries data; 0 = null word
axis_tlast  in  1  last word of packet
axis_tvalid  in  1  stream valid
axis_tready  out  1  stream ready
mem_wr_en  out  1  registered write request
mem_wr_addr  out  ADDR_WIDTH  write word address
mem_wr_data  out  32  write data
mem_wr_ready  in  1  arbiter accepts the write this cycle when mem_wr_en=1
err_clr  in  1  synchronous clear of sticky error flags
busy  out  1  packet in progress or write pending
done  out  1  one-cycle pulse on completion of a well-formed packet
err_len  out  1  sticky: header count = 0
err_short  out  1  sticky: tlast before count exhausted
err_long  out  1  sticky: count exhausted without tlast
pkt_count  out  16  good packets completed, wraps mod 2^16

Behaviour:
- Reset (async assert, sync-safe release): state=HDR, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, done=0, all err_*=0, pkt_count=0, busy=0. An in-flight packet is discarded; no partial write survives reset.
- AXIS beat = axis_tvalid & axis_tready. Memory accept = mem_wr_en & mem_wr_ready.
- Header word: [31:16] = N, the payload word count; [15:0] = base address.
- States:
  - HDR: axis_tready=1.
    - On a beat with tkeep=1: latch addr=base, remaining=N.
    - If N=0: set err_len; if tlast, stay in HDR; otherwise go to DRAIN.
    - If N>0 and tlast=1: set err_short and stay in HDR.
    - Otherwise go to DATA.
    - A tkeep=0 beat in HDR is ignored (no state change), including its tlast.
  - DATA: axis_tready = !mem_wr_en | mem_wr_ready (single output register, no combinational path from tvalid).
    - On a beat with tkeep=1: load mem_wr_en=1, mem_wr_addr=addr, mem_wr_data=tdata; addr += 1 mod 2^ADDR_WIDTH; remaining -= 1.
    - Word with remaining=1 and tlast=1: done pulses next cycle, pkt_count += 1, go to HDR.
    - Word with remaining=1 and tlast=0: word is written, err_long is set, go to DRAIN.
    - Word with remaining>1 and tlast=1: word is written, err_short is set, go to HDR, no done.
    - tkeep=0 beat: consumed, no write, no addr/remaining change; if tlast, set err_short and go to HDR.
  - DRAIN: axis_tready=1; discard beats until a beat with tlast, then go to HDR. No writes.
- mem_wr_en holds with stable addr/data until accepted; it clears the cycle after acceptance unless a new word is loaded in the same cycle (back-to-back, 1 word/cycle when mem_wr_ready=1).
- Write latency: AXIS beat to mem_wr_en = 1 cycle.
- busy = (state != HDR) | mem_wr_en.
- done is asserted with the loading of the final write. It does not wait for that write's acceptance.
- err_clr clears all err_* flags. If an error event occurs in the same cycle, the event wins and the flag stays set.
- An address increment past 2^ADDR_WIDTH-1 wraps to 0 silently.

Test Plan:
- Header 0x0003_0010, data A,B,C with tlast on C, mem_wr_ready=1 -> writes to 0x10,0x11,0x12 on consecutive cycles; done pulses once; pkt_count=1; no errors.
- Same packet with mem_wr_ready toggling 1,0,0,1… -> axis_tready drops while a write is pending; addr/data stable during the stall; all 3 writes land in order; no word lost or duplicated.
- ADDR_WIDTH=4, header 0x0002_000F -> writes to 0xF then 0x0 (wrap); done=1.
- Header 0x0002_0000, data X with tlast -> one write; err_short=1; state returns to HDR; the next good packet completes normally; pkt_count counts only the good packet.
- Header 0x0001_0020, data Y (no tlast), Z, W with tlast on W -> only Y written at 0x20; err_long=1; Z and W drained; then err_clr -> all flags 0.
- Header 0x0000_0000 without tlast followed by 2 beats, the second with tlast -> err_len=1, no writes; assert axis_aresetn=0 mid-DATA of a later packet -> all outputs at reset values immediately, no further writes.

Source files
------------

// File: rtl/gpu_axis_mem_loader_if.sv
// ============================================================================
// Module : gpu_axis_mem_loader_axis_if / gpu_axis_mem_loader_mem_if
// Brief  : Host AXI-Stream channel and data-memory write port bundles
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface gpu_axis_mem_loader_axis_if;
    logic [31:0] axis_tdata;
    logic        axis_tkeep;
    logic        axis_tlast;
    logic        axis_tvalid;
    logic        axis_tready;

    modport master (
        output axis_tdata,
        output axis_tkeep,
        output axis_tlast,
        output axis_tvalid,
        input  axis_tready
    );

    modport slave (
        input  axis_tdata,
        input  axis_tkeep,
        input  axis_tlast,
        input  axis_tvalid,
        output axis_tready
    );
endinterface

interface gpu_axis_mem_loader_mem_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [31:0]           mem_wr_data;
    logic                  mem_wr_ready;

    modport master (
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data,
        input  mem_wr_ready
    );

    modport slave (
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data,
        output mem_wr_ready
    );
endinterface

`default_nettype wire

// File: rtl/gpu_axis_mem_loader.sv
// ============================================================================
// Module : gpu_axis_mem_loader
// Brief  : Parses header+payload AXI-Stream packets into sequential
//          data-memory writes with backpressure and sticky error status.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gpu_axis_mem_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  axis_clk,
    input  wire logic                  axis_aresetn,
    gpu_axis_mem_loader_axis_if.slave  s_axis,
    gpu_axis_mem_loader_mem_if.master  m_mem,
    input  wire logic                  err_clr,
    output logic                       busy,
    output logic                       done,
    output logic                       err_len,
    output logic                       err_short,
    output logic                       err_long,
    output logic [15:0]                pkt_count
);

    typedef enum logic [1:0] {
        ST_HDR   = 2'd0,
        ST_DATA  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state,     w_state_nx;
    logic [ADDR_WIDTH-1:0] r_addr,      w_addr_nx;
    logic [15:0]           r_remaining, w_remaining_nx;
    logic                  r_wr_en,     w_wr_en_nx;
    logic [ADDR_WIDTH-1:0] r_wr_addr,   w_wr_addr_nx;
    logic [DATA_WIDTH-1:0] r_wr_data,   w_wr_data_nx;
    logic                  r_done,      w_done_nx;
    logic                  r_err_len,   w_err_len_nx;
    logic                  r_err_short, w_err_short_nx;
    logic                  r_err_long,  w_err_long_nx;
    logic [15:0]           r_pkt_count, w_pkt_count_nx;

    logic                  w_tready;
    logic                  w_beat;
    logic [15:0]           w_hdr_count;

    // In DATA the output register may only be reloaded once its word is accepted.
    assign w_tready    = (r_state == ST_DATA) ? (!r_wr_en || m_mem.mem_wr_ready) : 1'b1;
    assign w_beat      = s_axis.axis_tvalid && w_tready;
    assign w_hdr_count = s_axis.axis_tdata[31:16];

    always_comb begin
        w_state_nx     = r_state;
        w_addr_nx      = r_addr;
        w_remaining_nx = r_remaining;
        w_wr_en_nx     = r_wr_en && !m_mem.mem_wr_ready;
        w_wr_addr_nx   = r_wr_addr;
        w_wr_data_nx   = r_wr_data;
        w_done_nx      = 1'b0;
        // Clear first so a same-cycle error event below overrides it.
        w_err_len_nx   = r_err_len   && !err_clr;
        w_err_short_nx = r_err_short && !err_clr;
        w_err_long_nx  = r_err_long  && !err_clr;
        w_pkt_count_nx = r_pkt_count;

        case (r_state)
            ST_HDR: begin
                if (w_beat && s_axis.axis_tkeep) begin
                    w_addr_nx      = s_axis.axis_tdata[ADDR_WIDTH-1:0];
                    w_remaining_nx = w_hdr_count;
                    if (w_hdr_count == 16'd0) begin
                        w_err_len_nx = 1'b1;
                        w_state_nx   = s_axis.axis_tlast ? ST_HDR : ST_DRAIN;
                    end else if (s_axis.axis_tlast) begin
                        w_err_short_nx = 1'b1;
                    end else begin
                        w_state_nx = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (w_beat) begin
                    if (s_axis.axis_tkeep) begin
                        w_wr_en_nx     = 1'b1;
                        w_wr_addr_nx   = r_addr;
                        w_wr_data_nx   = s_axis.axis_tdata;
                        w_addr_nx      = r_addr + ADDR_WIDTH'(1);
                        w_remaining_nx = r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            if (s_axis.axis_tlast) begin
                                w_done_nx      = 1'b1;
                                w_pkt_count_nx = r_pkt_count + 16'd1;
                                w_state_nx     = ST_HDR;
                            end else begin
                                w_err_long_nx = 1'b1;
                                w_state_nx    = ST_DRAIN;
                            end
                        end else if (s_axis.axis_tlast) begin
                            w_err_short_nx = 1'b1;
                            w_state_nx     = ST_HDR;
                        end
                    end else if (s_axis.axis_tlast) begin
                        w_err_short_nx = 1'b1;
                        w_state_nx     = ST_HDR;
                    end
                end
            end

            ST_DRAIN: begin
                if (w_beat && s_axis.axis_tlast) begin
                    w_state_nx = ST_HDR;
                end
            end

            default: begin
                w_state_nx = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge axis_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state     <= ST_HDR;
            r_addr      <= '0;
            r_remaining <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_done      <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_addr      <= w_addr_nx;
            r_remaining <= w_remaining_nx;
            r_wr_en     <= w_wr_en_nx;
            r_wr_addr   <= w_wr_addr_nx;
            r_wr_data   <= w_wr_data_nx;
            r_done      <= w_done_nx;
            r_err_len   <= w_err_len_nx;
            r_err_short <= w_err_short_nx;
            r_err_long  <= w_err_long_nx;
            r_pkt_count <= w_pkt_count_nx;
        end
    end

    assign s_axis.axis_tready = w_tready;
    assign m_mem.mem_wr_en    = r_wr_en;
    assign m_mem.mem_wr_addr  = r_wr_addr;
    assign m_mem.mem_wr_data  = r_wr_data;
    assign busy               = (r_state != ST_HDR) || r_wr_en;
    assign done               = r_done;
    assign err_len            = r_err_len;
    assign err_short          = r_err_short;
    assign err_long           = r_err_long;
    assign pkt_count          = r_pkt_count;

endmodule

`default_nettype wire

// File: tb/tb_gpu_axis_mem_loader.sv
// ============================================================================
// Module : tb_gpu_axis_mem_loader
// Brief  : Scoreboard bench for gpu_axis_mem_loader (16-bit and 4-bit address)
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gpu_axis_mem_loader;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    always #5 clk = ~clk;

    gpu_axis_mem_loader_axis_if ax();
    gpu_axis_mem_loader_axis_if ax4();
    gpu_axis_mem_loader_mem_if #(.ADDR_WIDTH(16)) mm();
    gpu_axis_mem_loader_mem_if #(.ADDR_WIDTH(4))  mm4();

    logic        busy, done, err_len, err_short, err_long;
    logic [15:0] pkt_count;
    logic        busy4, done4, err_len4, err_short4, err_long4;
    logic [15:0] pkt_count4;

    assign ax4.axis_tdata    = ax.axis_tdata;
    assign ax4.axis_tkeep    = ax.axis_tkeep;
    assign ax4.axis_tlast    = ax.axis_tlast;
    assign ax4.axis_tvalid   = ax.axis_tvalid;
    assign mm4.mem_wr_ready  = mm.mem_wr_ready;

    gpu_axis_mem_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) u_dut (
        .axis_clk(clk), .axis_aresetn(rst_n), .s_axis(ax), .m_mem(mm),
        .err_clr(err_clr), .busy(busy), .done(done), .err_len(err_len),
        .err_short(err_short), .err_long(err_long), .pkt_count(pkt_count)
    );

    gpu_axis_mem_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) u_dut4 (
        .axis_clk(clk), .axis_aresetn(rst_n), .s_axis(ax4), .m_mem(mm4),
        .err_clr(err_clr), .busy(busy4), .done(done4), .err_len(err_len4),
        .err_short(err_short4), .err_long(err_long4), .pkt_count(pkt_count4)
    );

    exp_t q16[$];
    exp_t q4[$];
    int   acc_cyc[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   stall_seen = 0;
    int   cyc = 0;
    int   rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expw(input logic [15:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        q16.push_back(e);
        q4.push_back(e);
    endtask

    // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = never ready
    initial begin
        int pi = 0;
        mm.mem_wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    mm.mem_wr_ready = (pi % 4 == 0) || (pi % 4 == 3);
                    pi++;
                end
                2: mm.mem_wr_ready = 1'b0;
                default: mm.mem_wr_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pops on each accepted write, plus stall stability
    initial begin
        logic        p16, p4;
        logic [15:0] pa16;
        logic [3:0]  pa4;
        logic [31:0] pd16, pd4;
        exp_t        e;
        p16 = 1'b0; p4 = 1'b0; pa16 = '0; pa4 = '0; pd16 = '0; pd4 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (mm.mem_wr_en && mm.mem_wr_ready) begin
                    tests++;
                    if (q16.size() == 0) begin
                        fails++;
                        $display("FAIL wr16_unexpected: got addr=%h data=%h expected no write",
                                 mm.mem_wr_addr, mm.mem_wr_data);
                    end else begin
                        e = q16.pop_front();
                        acc_cyc.push_back(cyc);
                        if (mm.mem_wr_addr !== e.a || mm.mem_wr_data !== e.d) begin
                            fails++;
                            $display("FAIL wr16: got addr=%h data=%h expected addr=%h data=%h",
                                     mm.mem_wr_addr, mm.mem_wr_data, e.a, e.d);
                        end
                    end
                end
                if (mm4.mem_wr_en && mm4.mem_wr_ready) begin
                    tests++;
                    if (q4.size() == 0) begin
                        fails++;
                        $display("FAIL wr4_unexpected: got addr=%h data=%h expected no write",
                                 mm4.mem_wr_addr, mm4.mem_wr_data);
                    end else begin
                        e = q4.pop_front();
                        if (mm4.mem_wr_addr !== e.a[3:0] || mm4.mem_wr_data !== e.d) begin
                            fails++;
                            $display("FAIL wr4: got addr=%h data=%h expected addr=%h data=%h",
                                     mm4.mem_wr_addr, mm4.mem_wr_data, e.a[3:0], e.d);
                        end
                    end
                end
                if (p16) begin
                    tests++;
                    if (!(mm.mem_wr_en && mm.mem_wr_addr == pa16 && mm.mem_wr_data == pd16)) begin
                        fails++;
                        $display("FAIL stall16: got en=%b addr=%h data=%h expected en=1 addr=%h data=%h",
                                 mm.mem_wr_en, mm.mem_wr_addr, mm.mem_wr_data, pa16, pd16);
                    end
                end
                if (p4) begin
                    tests++;
                    if (!(mm4.mem_wr_en && mm4.mem_wr_addr == pa4 && mm4.mem_wr_data == pd4)) begin
                        fails++;
                        $display("FAIL stall4: got en=%b addr=%h data=%h expected en=1 addr=%h data=%h",
                                 mm4.mem_wr_en, mm4.mem_wr_addr, mm4.mem_wr_data, pa4, pd4);
                    end
                end
                if (mm.mem_wr_en && !mm.mem_wr_ready) stall_seen++;
                p16  = mm.mem_wr_en && !mm.mem_wr_ready;
                pa16 = mm.mem_wr_addr;
                pd16 = mm.mem_wr_data;
                p4   = mm4.mem_wr_en && !mm4.mem_wr_ready;
                pa4  = mm4.mem_wr_addr;
                pd4  = mm4.mem_wr_data;
                if (done === 1'b1) done_cnt++;
            end else begin
                p16 = 1'b0;
                p4  = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic k, input logic l);
        int n = 0;
        ax.axis_tdata  = d;
        ax.axis_tkeep  = k;
        ax.axis_tlast  = l;
        ax.axis_tvalid = 1'b1;
        @(negedge clk);
        while (!ax.axis_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got tready=0 for 100 cycles expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ax.axis_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        ax.axis_tvalid = 1'b0;
        @(negedge clk);
        while (!(q16.size() == 0 && q4.size() == 0 && !mm.mem_wr_en && !busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got q=%0d busy=%b expected q=0 busy=0", q16.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        int n;
        ax.axis_tdata = '0; ax.axis_tkeep = 1'b0; ax.axis_tlast = 1'b0; ax.axis_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en",   {31'd0, mm.mem_wr_en}, 32'd0);
        chk("rst_wr_addr", {16'd0, mm.mem_wr_addr}, 32'd0);
        chk("rst_wr_data", mm.mem_wr_data, 32'd0);
        chk("rst_flags",   {27'd0, busy, done, err_len, err_short, err_long}, 32'd0);
        chk("rst_pkt",     {16'd0, pkt_count}, 32'd0);
        chk("rst_tready",  {31'd0, ax.axis_tready}, 32'd1);
        rst_n = 1'b1;
        idle(2);

        // Good packet, full-rate memory
        acc_cyc.delete();
        expw(16'h0010, 32'hAAAA_0001);
        expw(16'h0011, 32'hBBBB_0002);
        expw(16'h0012, 32'hCCCC_0003);
        send(32'h0003_0010, 1'b1, 1'b0);
        send(32'hAAAA_0001, 1'b1, 1'b0);
        send(32'hBBBB_0002, 1'b1, 1'b0);
        send(32'hCCCC_0003, 1'b1, 1'b1);
        wait_drain();
        chk("p1_done", done_cnt, 32'd1);
        chk("p1_pkt", {16'd0, pkt_count}, 32'd1);
        chk("p1_errs", {29'd0, err_len, err_short, err_long}, 32'd0);
        chk("p1_b2b_span", (acc_cyc.size() == 3) ? (acc_cyc[2] - acc_cyc[0]) : -1, 32'd2);

        // Same packet with stalling memory
        rdy_mode = 1;
        expw(16'h0010, 32'h1111_0001);
        expw(16'h0011, 32'h2222_0002);
        expw(16'h0012, 32'h3333_0003);
        send(32'h0003_0010, 1'b1, 1'b0);
        send(32'h1111_0001, 1'b1, 1'b0);
        send(32'h2222_0002, 1'b1, 1'b0);
        send(32'h3333_0003, 1'b1, 1'b1);
        wait_drain();
        rdy_mode = 0;
        chk("p2_stalled", {31'd0, stall_seen > 0}, 32'd1);
        chk("p2_done", done_cnt, 32'd2);
        chk("p2_pkt", {16'd0, pkt_count}, 32'd2);

        // Base 0x000F: wraps only in the 4-bit instance
        expw(16'h000F, 32'h0F0F_0001);
        expw(16'h0010, 32'h0F0F_0002);
        send(32'h0002_000F, 1'b1, 1'b0);
        send(32'h0F0F_0001, 1'b1, 1'b0);
        send(32'h0F0F_0002, 1'b1, 1'b1);
        wait_drain();
        chk("p3_pkt", {16'd0, pkt_count}, 32'd3);
        chk("p3_pkt4", {16'd0, pkt_count4}, 32'd3);

        // Base 0xFFFF: wraps in both instances
        expw(16'hFFFF, 32'hFFFF_0001);
        expw(16'h0000, 32'hFFFF_0002);
        send(32'h0002_FFFF, 1'b1, 1'b0);
        send(32'hFFFF_0001, 1'b1, 1'b0);
        send(32'hFFFF_0002, 1'b1, 1'b1);
        wait_drain();
        chk("p4_pkt", {16'd0, pkt_count}, 32'd4);
        chk("p4_done", done_cnt, 32'd4);

        // Short packet then a good one
        expw(16'h0000, 32'h5555_0001);
        send(32'h0002_0000, 1'b1, 1'b0);
        send(32'h5555_0001, 1'b1, 1'b1);
        wait_drain();
        chk("short_errs", {29'd0, err_len, err_short, err_long}, 32'd2);
        chk("short_pkt", {16'd0, pkt_count}, 32'd4);
        chk("short_done", done_cnt, 32'd4);
        expw(16'h0030, 32'h3030_0001);
        send(32'h0001_0030, 1'b1, 1'b0);
        send(32'h3030_0001, 1'b1, 1'b1);
        wait_drain();
        chk("after_short_pkt", {16'd0, pkt_count}, 32'd5);
        chk("after_short_done", done_cnt, 32'd5);

        // Long packet: only Y written, rest drained
        pulse_clr();
        chk("clr1_errs", {29'd0, err_len, err_short, err_long}, 32'd0);
        expw(16'h0020, 32'h7777_0001);
        send(32'h0001_0020, 1'b1, 1'b0);
        send(32'h7777_0001, 1'b1, 1'b0);
        send(32'h7777_0002, 1'b1, 1'b0);
        send(32'h7777_0003, 1'b1, 1'b1);
        wait_drain();
        chk("long_errs", {29'd0, err_len, err_short, err_long}, 32'd1);
        chk("long_pkt", {16'd0, pkt_count}, 32'd5);
        pulse_clr();
        chk("clr2_errs", {29'd0, err_len, err_short, err_long}, 32'd0);

        // Null words: ignored in HDR, skipped in DATA
        expw(16'h0050, 32'h5050_0001);
        expw(16'h0051, 32'h5050_0002);
        send(32'hDEAD_BEEF, 1'b0, 1'b1);
        send(32'h0002_0050, 1'b1, 1'b0);
        send(32'h5050_0001, 1'b1, 1'b0);
        send(32'hDEAD_BEEF, 1'b0, 1'b0);
        send(32'h5050_0002, 1'b1, 1'b1);
        wait_drain();
        chk("null_pkt", {16'd0, pkt_count}, 32'd6);
        chk("null_errs", {29'd0, err_len, err_short, err_long}, 32'd0);

        // Zero-length header: error, drain, no writes
        send(32'h0000_0000, 1'b1, 1'b0);
        send(32'h9999_0001, 1'b1, 1'b0);
        send(32'h9999_0002, 1'b1, 1'b1);
        wait_drain();
        chk("len_errs", {29'd0, err_len, err_short, err_long}, 32'd4);
        chk("len_pkt", {16'd0, pkt_count}, 32'd6);

        // Reset mid-DATA with a write pending
        expw(16'h0060, 32'h6060_0001);
        expw(16'h0061, 32'h6060_0002);
        send(32'h0004_0060, 1'b1, 1'b0);
        send(32'h6060_0001, 1'b1, 1'b0);
        send(32'h6060_0002, 1'b1, 1'b0);
        ax.axis_tvalid = 1'b0;
        n = 0;
        while ((q16.size() != 0 || mm.mem_wr_en) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pre_rst_drained", q16.size(), 32'd0);
        rdy_mode = 2;
        idle(1);
        send(32'h6060_0003, 1'b1, 1'b0);
        ax.axis_tvalid = 1'b0;
        @(negedge clk);
        chk("pre_rst_pending", {31'd0, mm.mem_wr_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en",   {31'd0, mm.mem_wr_en}, 32'd0);
        chk("mid_rst_wr_addr", {16'd0, mm.mem_wr_addr}, 32'd0);
        chk("mid_rst_wr_data", mm.mem_wr_data, 32'd0);
        chk("mid_rst_flags",   {27'd0, busy, done, err_len, err_short, err_long}, 32'd0);
        chk("mid_rst_pkt",     {16'd0, pkt_count}, 32'd0);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(5);
        chk("post_rst_q", q16.size(), 32'd0);
        expw(16'h0070, 32'h7070_0001);
        send(32'h0001_0070, 1'b1, 1'b0);
        send(32'h7070_0001, 1'b1, 1'b1);
        wait_drain();
        chk("post_rst_pkt", {16'd0, pkt_count}, 32'd1);
        chk("post_rst_errs", {29'd0, err_len, err_short, err_long}, 32'd0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
